// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM states and
// the shift-count width derivation.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Wide enough to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_seq_dp.sv
// Shift register datapath: parallel load, one-position left/right shift or
// rotate-left per enabled cycle, and capture of the bit pushed out.
module shift_seq_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift_en,
  input  logic             i_dir_right,
  input  logic             i_rot,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ser_out
);

  logic [WIDTH-1:0] r_q;
  logic             r_ser;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_q   <= '0;
      r_ser <= 1'b0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift_en) begin
      if (i_dir_right) begin
        r_ser <= r_q[0];
        r_q   <= {1'b0, r_q[WIDTH-1:1]};
      end else begin
        r_ser <= r_q[WIDTH-1];
        r_q   <= {r_q[WIDTH-2:0], i_rot ? r_q[WIDTH-1] : 1'b0};
      end
    end
  end

  assign o_q       = r_q;
  assign o_ser_out = r_ser;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the shift register: accepts one command, counts it
// out one position per clock, pulses done. Rotate is enabled by SHIFT_SEQ_ROT_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_SHIFT = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_illegal;
  logic             w_rot_sel;
  logic             w_load;
  logic             w_shift_en;
  logic [CNT_W-1:0] w_count;

`ifdef SHIFT_SEQ_ROT_EN
  assign w_illegal = 1'b0;
  assign w_rot_sel = (r_op == OP_ROT);
`else
  assign w_illegal = (cmd_op == OP_ROT);
  assign w_rot_sel = 1'b0;
`endif

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // Logical shifts saturate at WIDTH; rotate runs the full requested count.
  assign w_count = ((cmd_op != OP_ROT) && (cmd_count > MAX_SHIFT)) ? MAX_SHIFT : cmd_count;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_LOAD)                  w_state_next = ST_LOAD;
          else if (w_illegal || w_count == '0)    w_state_next = ST_DONE;
          else                                    w_state_next = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = ST_DONE;
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_data  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_DONE);
      r_err   <= w_accept && w_illegal;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_data <= cmd_data;
        r_cnt  <= w_count;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign done = r_done;
  assign err  = r_err;

  shift_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_data     (r_data),
    .i_shift_en (w_shift_en),
    .i_dir_right(r_op == OP_SHR),
    .i_rot      (w_rot_sel),
    .o_q        (q),
    .o_ser_out  (ser_out)
  );

endmodule
